regfile_read_unit: RTL and testbench

REGFILE_READ_UNIT -- requirements
Module: regfile_read_unit

---
 rtl/regfile_read_unit.sv | 123 ++++++++++++
 tb/tb_regfile_read_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_read_unit.sv
`default_nettype none
// ============================================================================
// Module   : regfile_read_unit
// Brief    : Register-file read port with write bypass, a 2-entry response
//            FIFO and write-snoop refresh of held entries.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_read_unit #(
    parameter int WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [4:0]            req_addr,
    output logic                  req_ready,
    input  logic [32*WIDTH-1:0]   bank_data,
    input  logic                  wr_en,
    input  logic [4:0]            wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    output logic                  resp_valid,
    output logic [4:0]            resp_addr,
    output logic [WIDTH-1:0]      resp_data,
    input  logic                  resp_ready
);

    localparam logic [4:0] c_zero_reg = 5'd31;

    localparam logic [1:0] c_st_empty = 2'd0;
    localparam logic [1:0] c_st_one   = 2'd1;
    localparam logic [1:0] c_st_full  = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic                  r_wptr;
    logic                  r_rptr;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_snoop;
    logic [WIDTH-1:0]      w_push_data;

    logic [1:0][4:0]       w_ent_addr;
    logic [1:0][WIDTH-1:0] w_ent_data;

    assign req_ready  = (r_state != c_st_full);
    assign resp_valid = (r_state == c_st_one) || (r_state == c_st_full);
    assign resp_addr  = w_ent_addr[r_rptr];
    assign resp_data  = w_ent_data[r_rptr];

    assign w_push  = req_valid && req_ready;
    assign w_pop   = resp_valid && resp_ready;
    assign w_snoop = wr_en && (wr_addr != c_zero_reg);

    // Register 31 is hard-wired zero; a same-cycle write wins over the bank.
    always_comb begin
        w_push_data = bank_data[req_addr*WIDTH +: WIDTH];
        if (req_addr == c_zero_reg) begin
            w_push_data = '0;
        end else if (w_snoop && (wr_addr == req_addr)) begin
            w_push_data = wr_data;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_empty: if (w_push)           w_state_nxt = c_st_one;
            c_st_one: begin
                if (w_push && !w_pop)         w_state_nxt = c_st_full;
                else if (w_pop && !w_push)    w_state_nxt = c_st_empty;
            end
            c_st_full:  if (w_pop)            w_state_nxt = c_st_one;
            default:                          w_state_nxt = c_st_empty;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_empty;
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) r_wptr <= ~r_wptr;
            if (w_pop)  r_rptr <= ~r_rptr;
        end
    end

    generate
        for (genvar i = 0; i < 2; i++) begin : g_entry
            localparam logic c_idx = (i == 1);

            logic [4:0]       r_addr;
            logic [WIDTH-1:0] r_data;
            logic             w_held;
            logic             w_load;
            logic             w_refresh;

            // Only occupied slots are refreshed so a drained FIFO keeps stable data.
            assign w_held    = (r_state == c_st_full) ||
                               ((r_state == c_st_one) && (r_rptr == c_idx));
            assign w_load    = w_push && (r_wptr == c_idx);
            assign w_refresh = w_snoop && w_held && (r_addr == wr_addr);

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_addr <= '0;
                    r_data <= '0;
                end else if (w_load) begin
                    r_addr <= req_addr;
                    r_data <= w_push_data;
                end else if (w_refresh) begin
                    r_data <= wr_data;
                end
            end

            assign w_ent_addr[i] = r_addr;
            assign w_ent_data[i] = r_data;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_read_unit.sv
`default_nettype none
// Directed self-checking bench for regfile_read_unit.
module tb_regfile_read_unit;

    localparam int W = 64;

    logic               clk = 1'b0;
    logic               reset;
    logic               req_valid;
    logic [4:0]         req_addr;
    logic               req_ready;
    logic [32*W-1:0]    bank_data;
    logic               wr_en;
    logic [4:0]         wr_addr;
    logic [W-1:0]       wr_data;
    logic               resp_valid;
    logic [4:0]         resp_addr;
    logic [W-1:0]       resp_data;
    logic               resp_ready;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_read_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .bank_data  (bank_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .resp_valid (resp_valid),
        .resp_addr  (resp_addr),
        .resp_data  (resp_data),
        .resp_ready (resp_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_reg(input int idx, input logic [W-1:0] val);
        bank_data[idx*W +: W] = val;
    endtask

    task automatic req(input logic [4:0] a);
        req_valid = 1'b1;
        req_addr  = a;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        wr_en     = 1'b0;
    endtask

    initial begin
        reset = 1'b1; bank_data = '0; wr_addr = '0; wr_data = '0;
        resp_ready = 1'b1;
        for (int i = 0; i < 32; i++) set_reg(i, W'(64'h1000 + i));
        // Reset dominates a concurrent request and write.
        req(5'd5); wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hDEAD;
        step();
        idle();
        check("rst_valid", 64'(resp_valid), 64'd0);
        check("rst_addr",  64'(resp_addr),  64'd0);
        check("rst_data",  resp_data,       64'd0);
        check("rst_ready", 64'(req_ready),  64'd1);
        step();
        check("rst_hold_valid", 64'(resp_valid), 64'd0);
        reset = 1'b0;
        step();
        check("post_rst_valid", 64'(resp_valid), 64'd0);

        // Basic read
        set_reg(5, 64'hA5);
        req(5'd5);
        step();
        idle();
        check("basic_valid", 64'(resp_valid), 64'd1);
        check("basic_addr",  64'(resp_addr),  64'd5);
        check("basic_data",  resp_data,       64'hA5);
        step();
        check("basic_pop", 64'(resp_valid), 64'd0);

        // Zero register with concurrent write to r31
        set_reg(31, 64'hFFFF);
        req(5'd31); wr_en = 1'b1; wr_addr = 5'd31; wr_data = 64'd7;
        step();
        idle();
        check("zero_addr", 64'(resp_addr), 64'd31);
        check("zero_data", resp_data,      64'd0);
        step();

        // Write bypass
        set_reg(3, 64'h11);
        req(5'd3); wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h22;
        step();
        idle();
        check("bypass_data", resp_data, 64'h22);
        step();
        check("bypass_pop", 64'(resp_valid), 64'd0);

        // Backpressure and in-order drain
        set_reg(1, 64'h101); set_reg(2, 64'h202); set_reg(3, 64'h303);
        resp_ready = 1'b0;
        req(5'd1);
        step();
        check("bp_ready_one", 64'(req_ready), 64'd1);
        req(5'd2);
        step();
        check("bp_ready_full", 64'(req_ready), 64'd0);
        req(5'd3);
        step();
        check("bp_stall_ready", 64'(req_ready), 64'd0);
        check("bp_stall_addr",  64'(resp_addr), 64'd1);
        check("bp_stall_data",  resp_data,      64'h101);
        resp_ready = 1'b1;
        step();
        check("bp_head2_addr", 64'(resp_addr), 64'd2);
        check("bp_head2_data", resp_data,      64'h202);
        check("bp_head2_ready", 64'(req_ready), 64'd1);
        // Push and pop together from ONE: no bubble
        step();
        idle();
        check("bp_head3_valid", 64'(resp_valid), 64'd1);
        check("bp_head3_addr",  64'(resp_addr),  64'd3);
        check("bp_head3_data",  resp_data,       64'h303);
        step();
        check("bp_drained", 64'(resp_valid), 64'd0);

        // Refresh of a stalled head
        set_reg(4, 64'h44);
        resp_ready = 1'b0;
        req(5'd4);
        step();
        idle();
        check("ref_before", resp_data, 64'h44);
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 64'h99;
        step();
        idle();
        check("ref_data", resp_data,      64'h99);
        check("ref_addr", 64'(resp_addr), 64'd4);
        wr_en = 1'b1; wr_addr = 5'd6; wr_data = 64'h55;
        step();
        idle();
        check("ref_other_addr", resp_data, 64'h99);
        // Push and refresh of the same register in one cycle
        req(5'd4); wr_en = 1'b1; wr_addr = 5'd4; wr_data = 64'hAB;
        step();
        idle();
        check("ref_push_head", resp_data,      64'hAB);
        check("ref_push_full", 64'(req_ready), 64'd0);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check("ref_push_second_addr", 64'(resp_addr), 64'd4);
        check("ref_push_second_data", resp_data,      64'hAB);

        // Reset while FULL
        set_reg(7, 64'h77);
        req(5'd7);
        step();
        idle();
        check("mid_full", 64'(req_ready), 64'd0);
        reset = 1'b1; resp_ready = 1'b1;
        req(5'd2); wr_en = 1'b1; wr_addr = 5'd2; wr_data = 64'hBAD;
        step();
        idle();
        reset = 1'b0;
        check("mid_rst_valid", 64'(resp_valid), 64'd0);
        check("mid_rst_data",  resp_data,       64'd0);
        check("mid_rst_ready", 64'(req_ready),  64'd1);
        set_reg(2, 64'h2222);
        req(5'd2);
        step();
        idle();
        check("mid_after_valid", 64'(resp_valid), 64'd1);
        check("mid_after_data",  resp_data,       64'h2222);
        step();
        check("mid_after_pop", 64'(resp_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
